// File: rtl/branch_ctrl_pkg.sv
// Shared ISA definitions for the branch controller: widths, op codes, FSM states
// and the relative-offset sign extension helper.
package isa_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_AW    = 5;
  localparam int RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_BEQZ = 3'd1,
    OP_BNEZ = 3'd2,
    OP_JMP  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HALT = 3'd6,
    OP_RSVD = 3'd7
  } branch_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fsm_state_e;

  // Sign-extend the relative offset field to a full PC-width target.
  function automatic logic [PC_W-1:0] sext_off(input logic [LUT_AW-1:0] off);
    return {{(PC_W-LUT_AW){off[LUT_AW-1]}}, off};
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode-side, PC-side and LUT-init signals of the branch controller.
// master = decode/PC/init environment, slave = branch_ctrl.
interface branch_ctrl_if;
  import isa_pkg::*;

  logic              Start;
  logic [2:0]        BranchOp;
  logic [LUT_AW-1:0] Operand;
  logic              Zero;
  logic [PC_W-1:0]   ProgCtr;
  logic              LutWe;
  logic [LUT_AW-1:0] LutWAddr;
  logic [PC_W-1:0]   LutWData;
  logic              Jump;
  logic              BranchAbsOrRel;
  logic [PC_W-1:0]   Target;
  logic              Done;
  logic              RasErr;

  modport master (
    output Start, BranchOp, Operand, Zero, ProgCtr, LutWe, LutWAddr, LutWData,
    input  Jump, BranchAbsOrRel, Target, Done, RasErr
  );

  modport slave (
    input  Start, BranchOp, Operand, Zero, ProgCtr, LutWe, LutWAddr, LutWData,
    output Jump, BranchAbsOrRel, Target, Done, RasErr
  );

endinterface

// File: rtl/branch_ctrl_ras.sv
// Return-address stack: LIFO of DEPTH entries, pointer counts 0..DEPTH.
// Push is ignored when full and pop when empty; the caller flags those errors.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_m1;

  assign full   = (ptr == PW'(DEPTH));
  assign empty  = (ptr == '0);
  assign ptr_m1 = ptr - PW'(1);
  assign top    = empty ? '0 : mem[ptr_m1[AW-1:0]];

  // Stack pointer: emptied by reset, moves on a legal push or pop.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (Reset) begin
      ptr <= '0;
    end else if (push && !full) begin
      ptr <= ptr + PW'(1);
    end else if (pop && !empty) begin
      ptr <= ptr_m1;
    end
  end

  // Entry storage: written on a legal push.
  always_ff @(posedge Clk) begin
    // NOTE: storage is deliberately not reset; the pointer alone decides which entries are valid.
    if (push && !full) begin
      mem[ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: decodes branch ops into Jump/BranchAbsOrRel/Target for the
// PC register, owns the absolute-target LUT, the return stack and the
// IDLE/RUN/HALT sequencer.
module branch_ctrl
  import isa_pkg::*;
(
  input logic          Clk,
  input logic          Reset,
  branch_ctrl_if.slave bus
);

  fsm_state_e      state_q, state_d;
  branch_op_e      op;
  logic [PC_W-1:0] lut [2**LUT_AW];
  logic [PC_W-1:0] lut_rd;
  logic [PC_W-1:0] stk_top;
  logic [PC_W-1:0] ret_addr;
  logic            stk_full, stk_empty;
  logic            push, pop, err_set;
  logic            jump, rel;
  logic [PC_W-1:0] target;
  logic            done_q, ras_err_q;

  assign op       = branch_op_e'(bus.BranchOp);
  assign lut_rd   = lut[bus.Operand];
  assign ret_addr = bus.ProgCtr + PC_W'(1);

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Absolute-target LUT: write lands on the edge, so a same-cycle read sees old data.
  always_ff @(posedge Clk) begin
    if (bus.LutWe) begin
      lut[bus.LutWAddr] <= bus.LutWData;
    end
  end

  // Next state, zero-latency decode outputs and stack commands.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    state_d = state_q;
    jump    = 1'b0;
    rel     = 1'b0;
    target  = '0;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.Start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.Start) begin
            state_d = ST_IDLE;
          end else begin
            unique case (op)
              OP_BEQZ: begin
                jump   = bus.Zero;
                rel    = 1'b1;
                target = sext_off(bus.Operand);
              end
              OP_BNEZ: begin
                jump   = ~bus.Zero;
                rel    = 1'b1;
                target = sext_off(bus.Operand);
              end
              OP_JMP: begin
                jump   = 1'b1;
                target = lut_rd;
              end
              OP_CALL: begin
                jump   = 1'b1;
                target = lut_rd;
                if (stk_full) err_set = 1'b1;
                else          push    = 1'b1;
              end
              OP_RET: begin
                jump   = 1'b1;
                target = stk_top;
                if (stk_empty) err_set = 1'b1;
                else           pop     = 1'b1;
              end
              OP_HALT: begin
                jump    = 1'b1;
                rel     = 1'b1;
                state_d = ST_HALT;
              end
              default: ;
            endcase
          end
        end
        ST_HALT: begin
          jump = 1'b1;
          rel  = 1'b1;
          if (bus.Start) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register plus registered Done and sticky RasErr.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      ras_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == ST_HALT);
      if (err_set) ras_err_q <= 1'b1;
    end
  end

  assign bus.Jump           = jump;
  assign bus.BranchAbsOrRel = rel;
  assign bus.Target         = target;
  assign bus.Done           = done_q;
  assign bus.RasErr         = ras_err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios followed by random
// cycles, all compared against a queue/array reference model.
module tb_branch_ctrl;
  import isa_pkg::*;

  logic Clk;
  logic Reset;
  int   total_checks;
  int   passed_checks;

  branch_ctrl_if bus ();

  branch_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: sequencer flags, LIFO of return addresses, LUT image.
  bit         m_running;
  bit         m_halted;
  bit         m_done;
  bit         m_err;
  logic [9:0] m_stk [$];
  logic [9:0] m_lut [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    else passed_checks++;
  endtask

  // One clock cycle: drive at negedge, check outputs, advance model on posedge.
  task automatic cyc(input bit rst_i, input bit st, input logic [2:0] op_i,
                     input logic [4:0] opd, input bit z, input logic [9:0] pc,
                     input bit we, input logic [4:0] wa, input logic [9:0] wd);
    bit         ej, er;
    logic [9:0] et;
    int         off;
    logic [9:0] ra;
    Reset        = rst_i;
    bus.Start    = st;
    bus.BranchOp = op_i;
    bus.Operand  = opd;
    bus.Zero     = z;
    bus.ProgCtr  = pc;
    bus.LutWe    = we;
    bus.LutWAddr = wa;
    bus.LutWData = wd;
    ej = 1'b0; er = 1'b0; et = '0;
    off = (opd >= 5'd16) ? int'(opd) - 32 : int'(opd);
    if (!rst_i) begin
      if (m_halted) begin
        ej = 1'b1; er = 1'b1;
      end else if (m_running && !st) begin
        case (op_i)
          3'd1: begin ej = z;  er = 1'b1; et = 10'(off); end
          3'd2: begin ej = !z; er = 1'b1; et = 10'(off); end
          3'd3, 3'd4: begin ej = 1'b1; et = m_lut[opd]; end
          3'd5: begin ej = 1'b1; et = (m_stk.size() > 0) ? m_stk[$] : 10'd0; end
          3'd6: begin ej = 1'b1; er = 1'b1; end
          default: ;
        endcase
      end
    end
    #1;
    check("jump",   32'(bus.Jump),           32'(ej));
    check("rel",    32'(bus.BranchAbsOrRel), 32'(er));
    check("target", 32'(bus.Target),         32'(et));
    check("done",   32'(bus.Done),           32'(m_done));
    check("raserr", 32'(bus.RasErr),         32'(m_err));
    @(posedge Clk);
    if (rst_i) begin
      m_running = 1'b0; m_halted = 1'b0; m_err = 1'b0;
      m_stk.delete();
    end else if (m_halted) begin
      if (st) m_halted = 1'b0;
    end else if (!m_running) begin
      if (!st) m_running = 1'b1;
    end else if (st) begin
      m_running = 1'b0;
    end else begin
      case (op_i)
        3'd4: begin
          ra = pc + 10'd1;
          if (m_stk.size() == RAS_DEPTH) m_err = 1'b1;
          else m_stk.push_back(ra);
        end
        3'd5: begin
          if (m_stk.size() == 0) m_err = 1'b1;
          else void'(m_stk.pop_back());
        end
        3'd6: begin m_running = 1'b0; m_halted = 1'b1; end
        default: ;
      endcase
    end
    m_done = m_halted;
    if (we) m_lut[wa] = wd;
    @(negedge Clk);
  endtask

  task automatic run_op(input logic [2:0] op_i, input logic [4:0] opd,
                        input bit z, input logic [9:0] pc);
    cyc(1'b0, 1'b0, op_i, opd, z, pc, 1'b0, 5'd0, 10'd0);
  endtask

  task automatic idle_cyc(input bit rst_i, input bit st);
    cyc(rst_i, st, 3'd0, 5'd0, 1'b0, 10'd0, 1'b0, 5'd0, 10'd0);
  endtask

  initial begin
    logic [9:0] wd;
    total_checks  = 0;
    passed_checks = 0;
    m_running = 1'b0; m_halted = 1'b0; m_done = 1'b0; m_err = 1'b0;
    Reset = 1'b1;
    bus.Start = 1'b1; bus.BranchOp = 3'd0; bus.Operand = '0; bus.Zero = 1'b0;
    bus.ProgCtr = '0; bus.LutWe = 1'b0; bus.LutWAddr = '0; bus.LutWData = '0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);

    // Reset state, then fill the LUT while held in IDLE.
    idle_cyc(1'b1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      wd = (i == 3) ? 10'h120 : 10'($urandom_range(0, 1023));
      cyc(1'b0, 1'b1, 3'd0, 5'd0, 1'b0, 10'd0, 1'b1, 5'(i), wd);
    end

    // Start falls -> RUN, then JMP through LUT[3].
    idle_cyc(1'b0, 1'b0);
    run_op(3'd3, 5'd3, 1'b0, 10'h010);

    // BEQZ with negative offset, taken and not taken; BNEZ both ways.
    run_op(3'd1, 5'h1E, 1'b1, 10'h020);
    run_op(3'd1, 5'h1E, 1'b0, 10'h021);
    run_op(3'd2, 5'h0F, 1'b0, 10'h022);
    run_op(3'd2, 5'h10, 1'b1, 10'h023);

    // CALL at the top of the PC space pushes a wrapped return address.
    run_op(3'd4, 5'd7, 1'b0, 10'h3FF);
    run_op(3'd0, 5'd0, 1'b0, 10'h100);
    run_op(3'd5, 5'd0, 1'b0, 10'h101);

    // Overfill the stack, then drain it one past empty.
    for (int i = 0; i < 5; i++) run_op(3'd4, 5'(i), 1'b0, 10'(10'h040 + 10'(i * 16)));
    for (int i = 0; i < 5; i++) run_op(3'd5, 5'd0, 1'b0, 10'h200);

    // LUT write with a same-cycle JMP to that index sees the old entry.
    cyc(1'b0, 1'b0, 3'd3, 5'd3, 1'b0, 10'h050, 1'b1, 5'd3, 10'h2AA);
    run_op(3'd3, 5'd3, 1'b0, 10'h051);

    // HALT holds the PC for 10 cycles, Start pulse returns to IDLE.
    run_op(3'd6, 5'd0, 1'b0, 10'h060);
    for (int i = 0; i < 10; i++) run_op(3'd0, 5'd0, 1'b0, 10'h060);
    idle_cyc(1'b0, 1'b1);
    idle_cyc(1'b0, 1'b1);

    // Reset in the middle of RUN after two CALLs.
    idle_cyc(1'b0, 1'b0);
    run_op(3'd4, 5'd1, 1'b0, 10'h070);
    run_op(3'd4, 5'd2, 1'b0, 10'h080);
    idle_cyc(1'b1, 1'b0);
    idle_cyc(1'b0, 1'b1);
    idle_cyc(1'b0, 1'b0);
    run_op(3'd5, 5'd0, 1'b0, 10'h090);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
          3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
          10'($urandom_range(0, 1023)), ($urandom_range(0, 7) == 0),
          5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)));
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
